// File: rtl/instruction_loader.sv
// instruction_loader: boot-time program loader.
// Assembles a byte stream (MSB first) into SIZE-bit words. Each word is written to
// consecutive instruction-memory addresses while the CPU is held stalled. The load
// ends on HALT_WORD (which is itself written) or when the memory is full. The CPU
// then gets a one-cycle reset pulse and is released.
//
// Handshake: i_rx_valid is a one-cycle qualifier with no backpressure, so one byte
// is taken per pulse. Bytes are taken only in RECV and WRITE. A byte arriving in the
// WRITE cycle becomes byte 0 of the next word. o_inst_write_enable is high for
// exactly one cycle per word, with o_write_addr and o_write_data stable in that cycle.
module instruction_loader #(
  parameter int unsigned        SIZE            = 32,
  parameter int unsigned        MAX_INSTRUCTION = 64,
  parameter logic [SIZE-1:0]    HALT_WORD       = {SIZE{1'b1}},
  localparam int unsigned       ADDR_WIDTH      = (MAX_INSTRUCTION > 1) ? $clog2(MAX_INSTRUCTION) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_inst_write_enable,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic [SIZE-1:0]       o_write_data,
  output logic                  o_stall,
  output logic                  o_cpu_rst,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  localparam int unsigned NB  = SIZE / 8;
  localparam int unsigned BCW = $clog2(NB + 1);
  localparam logic [BCW-1:0]        LAST_BYTE = BCW'(NB - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_INSTRUCTION - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    WRITE   = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t          state;
  logic [BCW-1:0]  byte_cnt;
  logic [SIZE-1:0] sr;
  logic [SIZE-1:0] shifted;

  // Shift register contents after the incoming byte is appended as the LSB.
  assign shifted = (sr << 8) | SIZE'(i_rx_data);

  // Loader FSM with all outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state               <= IDLE;
      byte_cnt            <= '0;
      sr                  <= '0;
      o_inst_write_enable <= 1'b0;
      o_write_addr        <= '0;
      o_write_data        <= '0;
      o_stall             <= 1'b1;
      o_cpu_rst           <= 1'b0;
      o_busy              <= 1'b0;
      o_done              <= 1'b0;
      o_word_count        <= '0;
    end else begin
      o_inst_write_enable <= 1'b0;
      o_cpu_rst           <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state        <= RECV;
            o_write_addr <= '0;
            o_word_count <= '0;
            byte_cnt     <= '0;
            o_busy       <= 1'b1;
          end
        end
        RECV: begin
          if (i_rx_valid) begin
            sr <= shifted;
            if (byte_cnt == LAST_BYTE) begin
              o_write_data        <= shifted;
              o_inst_write_enable <= 1'b1;
              byte_cnt            <= '0;
              state               <= WRITE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          o_word_count <= o_word_count + 1'b1;
          if (o_write_data == HALT_WORD || o_write_addr == LAST_ADDR) begin
            // Last word of the load: later bytes are dropped.
            state     <= RELEASE;
            o_busy    <= 1'b0;
            o_cpu_rst <= 1'b1;
            byte_cnt  <= '0;
          end else begin
            o_write_addr <= o_write_addr + 1'b1;
            state        <= RECV;
            if (i_rx_valid) begin
              // Streaming byte: it starts the next word.
              sr <= shifted;
              if (LAST_BYTE == '0) begin
                o_write_data        <= shifted;
                o_inst_write_enable <= 1'b1;
                byte_cnt            <= '0;
                state               <= WRITE;
              end else begin
                byte_cnt <= BCW'(1);
              end
            end else begin
              byte_cnt <= '0;
            end
          end
        end
        RELEASE: begin
          state   <= DONE;
          o_stall <= 1'b0;
          o_done  <= 1'b1;
        end
        DONE: begin
          if (i_start) begin
            state        <= RECV;
            o_stall      <= 1'b1;
            o_done       <= 1'b0;
            o_write_addr <= '0;
            o_word_count <= '0;
            byte_cnt     <= '0;
            o_busy       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: a behavioural model checked every cycle, plus
// literal expectations on the write log for directed loads.
module tb_instruction_loader;

  localparam int SIZE = 32;
  localparam int MAXI = 8;
  localparam int AW   = 3;
  localparam int NB   = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_start;
  logic [7:0]    i_rx_data;
  logic          i_rx_valid;
  logic          o_inst_write_enable;
  logic [AW-1:0] o_write_addr;
  logic [31:0]   o_write_data;
  logic          o_stall;
  logic          o_cpu_rst;
  logic          o_busy;
  logic          o_done;
  logic [AW:0]   o_word_count;

  instruction_loader #(
    .SIZE(SIZE),
    .MAX_INSTRUCTION(MAXI),
    .HALT_WORD(HALT)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid),
    .o_inst_write_enable(o_inst_write_enable),
    .o_write_addr(o_write_addr),
    .o_write_data(o_write_data),
    .o_stall(o_stall),
    .o_cpu_rst(o_cpu_rst),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_word_count(o_word_count)
  );

  // Clock and reset defaults.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model: a loading session and the expected outputs.
  bit          m_loading;
  bit          m_final;
  int          m_nbytes;
  logic [31:0] m_word;
  logic          e_we, e_stall, e_cpu_rst, e_busy, e_done;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_data;
  logic [AW:0]   e_count;

  // Actual writes seen at the memory port.
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  int            rst_pulses;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 0; m_final = 0; m_nbytes = 0; m_word = '0;
    e_we = 0; e_stall = 1; e_cpu_rst = 0; e_busy = 0; e_done = 0;
    e_addr = '0; e_data = '0; e_count = '0;
  endtask

  // One clock edge of the model, using the inputs present at the edge.
  task automatic model_step();
    bit pw, pr, ld0;
    pw = e_we; pr = e_cpu_rst; ld0 = m_loading;
    e_we = 0; e_cpu_rst = 0;
    if (pw) begin
      e_count = e_count + 1'b1;
      if (m_final) e_cpu_rst = 1;
      else e_addr = e_addr + 1'b1;
    end
    if (pr) begin
      e_done = 1; e_stall = 0;
    end
    if (i_rx_valid && m_loading) begin
      m_word = {m_word[23:0], i_rx_data};
      m_nbytes++;
      if (m_nbytes == NB) begin
        m_nbytes = 0;
        e_we = 1;
        e_data = m_word;
        if (m_word == HALT || int'(e_addr) == MAXI - 1) begin
          m_loading = 0; m_final = 1;
        end else begin
          m_final = 0;
        end
      end
    end
    if (i_start && !ld0 && !pw && !pr) begin
      m_loading = 1; m_nbytes = 0;
      e_addr = '0; e_count = '0; e_done = 0; e_stall = 1;
    end
    e_busy = m_loading || e_we;
  endtask

  // Per-cycle compare against the model, plus the write/pulse monitor.
  initial begin
    forever begin
      @(negedge i_clk);
      if (chk_en) begin
        chk("we",    64'(o_inst_write_enable), 64'(e_we));
        chk("addr",  64'(o_write_addr),        64'(e_addr));
        chk("data",  64'(o_write_data),        64'(e_data));
        chk("stall", 64'(o_stall),             64'(e_stall));
        chk("cpu_rst", 64'(o_cpu_rst),         64'(e_cpu_rst));
        chk("busy",  64'(o_busy),              64'(e_busy));
        chk("done",  64'(o_done),              64'(e_done));
        chk("count", 64'(o_word_count),        64'(e_count));
      end
      if (o_inst_write_enable === 1'b1) begin
        wr_addr_q.push_back(o_write_addr);
        wr_data_q.push_back(o_write_data);
      end
      if (o_cpu_rst === 1'b1) rst_pulses++;
    end
  end

  // Driver tasks: inputs are applied 1 time unit after the active edge.
  task automatic tick(input logic st, input logic v, input logic [7:0] b);
    i_start = st; i_rx_valid = v; i_rx_data = b;
    @(posedge i_clk);
    if (i_rst_n) model_step();
    else model_reset();
    #1;
    i_start = 0; i_rx_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    tick(0, 1, b);
    if (gaps) idle($urandom_range(0, 2));
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], gaps);
  endtask

  task automatic do_reset();
    #2;
    i_rst_n = 0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    rst_pulses = 0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 20; k++) begin
      if (o_done) break;
      tick(0, 0, 8'h00);
    end
    if (!o_done) begin
      n_tests++; n_fail++;
      $display("FAIL %s: timeout waiting for done", nm);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    do w = $urandom(); while (w == HALT);
    return w;
  endfunction

  logic [31:0] words[4];

  initial begin
    i_rst_n = 1; i_start = 0; i_rx_valid = 0; i_rx_data = '0;
    model_reset();
    do_reset();
    chk_en = 1;
    idle(2);

    // Two-word program ending with the halt marker.
    clear_log();
    tick(1, 0, 8'h00);
    send_word(32'h2001_0005, 1);
    send_word(HALT, 1);
    wait_done("t2_done");
    chk("t2_nwrites", 64'(wr_addr_q.size()), 64'd2);
    if (wr_addr_q.size() == 2) begin
      chk("t2_addr0", 64'(wr_addr_q[0]), 64'd0);
      chk("t2_data0", 64'(wr_data_q[0]), 64'h2001_0005);
      chk("t2_addr1", 64'(wr_addr_q[1]), 64'd1);
      chk("t2_data1", 64'(wr_data_q[1]), 64'hFFFF_FFFF);
    end
    chk("t2_count", 64'(o_word_count), 64'd2);
    chk("t2_rst_pulses", 64'(rst_pulses), 64'd1);
    chk("t2_stall", 64'(o_stall), 64'd0);
    idle(2);

    // Memory full without a halt word; trailing bytes are ignored.
    clear_log();
    tick(1, 0, 8'h00);
    for (int w = 0; w < MAXI; w++) send_word(rand_word(), 0);
    for (int k = 0; k < 4; k++) send_byte(8'h5A, 0);
    wait_done("t3_done");
    idle(3);
    chk("t3_nwrites", 64'(wr_addr_q.size()), 64'(MAXI));
    for (int w = 0; w < MAXI && w < wr_addr_q.size(); w++)
      chk("t3_addr", 64'(wr_addr_q[w]), 64'(w));
    chk("t3_count", 64'(o_word_count), 64'(MAXI));
    chk("t3_rst_pulses", 64'(rst_pulses), 64'd1);

    // Reset in the middle of a load, then a fresh load discards the partial word.
    clear_log();
    tick(1, 0, 8'h00);
    send_word(32'h1234_5678, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reset();
    chk("t1_stall", 64'(o_stall), 64'd1);
    chk("t1_done",  64'(o_done), 64'd0);
    chk("t1_we",    64'(o_inst_write_enable), 64'd0);
    chk("t1_addr",  64'(o_write_addr), 64'd0);
    chk("t1_count", 64'(o_word_count), 64'd0);
    clear_log();
    tick(1, 0, 8'h00);
    send_word(32'hAABB_CCDD, 1);
    idle(3);
    chk("t4_nwrites", 64'(wr_addr_q.size()), 64'd1);
    if (wr_addr_q.size() == 1) begin
      chk("t4_addr0", 64'(wr_addr_q[0]), 64'd0);
      chk("t4_data0", 64'(wr_data_q[0]), 64'hAABB_CCDD);
    end
    send_word(HALT, 0);
    wait_done("t4_done");
    idle(2);

    // Restart from DONE, then stream bytes on every cycle with a stray start pulse.
    clear_log();
    tick(1, 0, 8'h00);
    chk("t6_stall", 64'(o_stall), 64'd1);
    chk("t6_done",  64'(o_done), 64'd0);
    for (int w = 0; w < 3; w++) words[w] = rand_word();
    words[3] = HALT;
    for (int w = 0; w < 4; w++)
      for (int k = 3; k >= 0; k--)
        tick((w == 1 && k == 2) ? 1'b1 : 1'b0, 1'b1, words[w][k*8 +: 8]);
    wait_done("t5_done");
    chk("t5_nwrites", 64'(wr_addr_q.size()), 64'd4);
    for (int w = 0; w < 4 && w < wr_addr_q.size(); w++) begin
      chk("t5_addr", 64'(wr_addr_q[w]), 64'(w));
      chk("t5_data", 64'(wr_data_q[w]), 64'(words[w]));
    end
    chk("t5_count", 64'(o_word_count), 64'd4);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom());
      if ($urandom_range(0, 999) == 0) do_reset();
      tick(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0, b);
    end

    idle(2);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
